// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master drives operands and result acceptance; slave is the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             overflow_o;
  logic             zero_o;

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o, zero_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o, zero_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first,
// with a registered borrow; WIDTH cycles from operand accept to result valid.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb, b_msb;
  logic             a_k, b_k, d_k, br_nxt;

  assign a_k    = a_sh[0];
  assign b_k    = b_sh[0];
  assign d_k    = a_k ^ b_k ^ br;
  assign br_nxt = (~a_k & b_k) | (~(a_k ^ b_k) & br);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            a_sh  <= bus.a_i;
            b_sh  <= bus.b_i;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          res  <= {d_k, res[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            a_msb <= a_k;
            b_msb <= b_k;
          end
        end
        default: ;
      endcase
    end
  end

  // Result ports follow the registers directly; only out_valid_o qualifies them.
  assign bus.diff_o     = res;
  assign bus.borrow_o   = br;
  assign bus.zero_o     = (res == '0);
  assign bus.overflow_o = (a_msb != b_msb) & (res[WIDTH-1] != a_msb);
endmodule
